// File: rtl/wb_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_scoreboard_if
// Description : Bundle of the decode / writeback / flush signals seen by the
//               writeback scoreboard.
//               master : decode, writeback and flush unit (drives requests)
//               slave  : the scoreboard (drives D_stall, full, count, wb_err)
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_scoreboard_if #(
    parameter int PTR_W = 2
);
    // issue (decode -> execute)
    logic             issue_valid;
    logic             issue_use_rd;
    logic [4:0]       issue_rd;
    // decode operands under hazard check
    logic [4:0]       D_rs1;
    logic [4:0]       D_rs2;
    logic             is_D_use_rs1;
    logic             is_D_use_rs2;
    // writeback commit
    logic             wb_valid;
    logic             wb_use_rd;
    logic [4:0]       wb_rd;
    // flush of youngest entries
    logic [2:0]       flush_cnt;
    // scoreboard status
    logic             D_stall;
    logic             full;
    logic [PTR_W:0]   count;
    logic             wb_err;

    modport master (
        output issue_valid, issue_use_rd, issue_rd,
        output D_rs1, D_rs2, is_D_use_rs1, is_D_use_rs2,
        output wb_valid, wb_use_rd, wb_rd, flush_cnt,
        input  D_stall, full, count, wb_err
    );

    modport slave (
        input  issue_valid, issue_use_rd, issue_rd,
        input  D_rs1, D_rs2, is_D_use_rs1, is_D_use_rs2,
        input  wb_valid, wb_use_rd, wb_rd, flush_cnt,
        output D_stall, full, count, wb_err
    );
endinterface
`default_nettype wire

// File: rtl/wb_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : wb_scoreboard
// Description : In-order tracker of destination registers issued from D that
//               have not yet written back. Raises D_stall when a decode source
//               operand depends on an in-flight write the W->D bypass cannot
//               cover, or when the buffer is full and nothing retires.
// Ports       : clk - clock, all updates on rising edge
//               rst - synchronous active-high reset
//               sb  - wb_scoreboard_if.slave (issue / operands / writeback /
//                     flush inputs; D_stall, full, count, wb_err outputs)
// Revision    : 1.0 - initial release
// ============================================================================
module wb_scoreboard #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  wire logic           clk,
    input  wire logic           rst,
    wb_scoreboard_if.slave      sb
);

    localparam logic [PTR_W:0] C_DEPTH = (PTR_W+1)'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [4:0]       r_tag [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;
    logic             r_err;

    // ------------------------------------------------------------------
    // Writeback / issue qualification
    // ------------------------------------------------------------------
    logic w_pop_req;     // W commits a real register write
    logic w_pop;         // ... and there is an entry to retire
    logic w_full;
    logic w_stall;
    logic w_push;

    assign w_pop_req = sb.wb_valid & sb.wb_use_rd & (sb.wb_rd != 5'd0);
    assign w_pop     = w_pop_req & (r_count != '0);
    assign w_full    = (r_count == C_DEPTH);

    // ------------------------------------------------------------------
    // Hazard compare: each slot is live if it lies within count entries of
    // head. The head slot is dropped from the compare while it retires,
    // since the W->D bypass forwards that value this cycle.
    // ------------------------------------------------------------------
    logic [DEPTH-1:0] w_hit1;
    logic [DEPTH-1:0] w_hit2;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [PTR_W-1:0] w_off;
            logic             w_live;
            assign w_off     = PTR_W'(gi) - r_head;
            assign w_live    = ({1'b0, w_off} < r_count) & ~(w_pop & (w_off == '0));
            assign w_hit1[gi] = w_live & (r_tag[gi] == sb.D_rs1);
            assign w_hit2[gi] = w_live & (r_tag[gi] == sb.D_rs2);
        end
    endgenerate

    logic w_hit_rs1;
    logic w_hit_rs2;

    assign w_hit_rs1 = sb.is_D_use_rs1 & (sb.D_rs1 != 5'd0) & (|w_hit1);
    assign w_hit_rs2 = sb.is_D_use_rs2 & (sb.D_rs2 != 5'd0) & (|w_hit2);
    assign w_stall   = w_hit_rs1 | w_hit_rs2
                     | (w_full & sb.issue_valid & sb.issue_use_rd & ~w_pop_req);

    // A flushed cycle also kills the D instruction, so no push then.
    assign w_push = sb.issue_valid & sb.issue_use_rd & (sb.issue_rd != 5'd0)
                  & ~w_stall & (sb.flush_cnt == 3'd0);

    // ------------------------------------------------------------------
    // Next-state computation
    // ------------------------------------------------------------------
    int               w_cnt_pop;   // entries remaining after this cycle's pop
    int               w_flush_n;
    logic [PTR_W-1:0] w_head_nxt;
    logic [PTR_W-1:0] w_tail_nxt;
    logic [PTR_W:0]   w_count_nxt;
    logic             w_err_nxt;

    always_comb begin
        w_cnt_pop   = int'(r_count) - (w_pop ? 1 : 0);
        w_flush_n   = int'(sb.flush_cnt);
        w_head_nxt  = w_pop ? (r_head + 1'b1) : r_head;
        w_tail_nxt  = r_tail;
        w_count_nxt = (PTR_W+1)'(w_cnt_pop);
        w_err_nxt   = r_err;

        // Commit on empty, or commit whose rd is not the oldest tag.
        if (w_pop_req && ((r_count == '0) || (r_tag[r_head] != sb.wb_rd))) begin
            w_err_nxt = 1'b1;
        end

        if (w_flush_n > 0) begin
            if (w_flush_n > w_cnt_pop) begin
                // Over-flush: clamp to empty.
                w_count_nxt = '0;
                w_tail_nxt  = w_head_nxt;
                w_err_nxt   = 1'b1;
            end else begin
                w_count_nxt = (PTR_W+1)'(w_cnt_pop - w_flush_n);
                w_tail_nxt  = r_tail - PTR_W'(w_flush_n);
            end
        end else if (w_push) begin
            w_tail_nxt  = r_tail + 1'b1;
            w_count_nxt = (PTR_W+1)'(w_cnt_pop + 1);
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
            r_count <= w_count_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Tag storage needs no reset: slots outside the live window are ignored.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_tag[r_tail] <= sb.issue_rd;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign sb.D_stall = w_stall;
    assign sb.full    = w_full;
    assign sb.count   = r_count;
    assign sb.wb_err  = r_err;

endmodule
`default_nettype wire
